// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the CPU memory-bus SRAM responder:
//   - bus_state_t : responder state machine encoding
//   - WORD_BYTES  : bytes per bus word
//   - ADDR_LSB    : lowest byte-address bit that forms the word index
//   - addr_bad()  : misaligned / out-of-range check for an incoming address
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY,
        WDONE
    } bus_state_t;

    // An access is bad when it is not word aligned, or when its word index
    // needs more than index_bits bits (the array depth is a power of two).
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input int unsigned index_bits);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[ADDR_LSB-1:0] != '0);
        out_of_range = ((addr >> (ADDR_LSB + index_bits)) != '0);
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/sram_1p.sv
// -----------------------------------------------------------------------------
// sram_1p
// Synchronous single-port RAM, 32-bit words, one access per clock.
// Ports:
//   clk   in   clock
//   en    in   access enable
//   we    in   write enable (only meaningful with en)
//   addr  in   word index
//   wdata in   write data
//   rdata out  read data, updated the cycle after a read; holds otherwise
// -----------------------------------------------------------------------------
module sram_1p #(
    parameter int    DEPTH_WORDS = 4096,
    parameter string INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset; clearing thousands of words is neither
    // possible in one cycle nor wanted, since contents must survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bus_sram.sv
// -----------------------------------------------------------------------------
// bus_sram
// Responder on the CPU memory bus backed by a single-port SRAM. Inserts
// WAIT_STATES wait cycles before each array access and flags misaligned or
// out-of-range accesses on bus_err.
// Ports:
//   clk          in   bus clock
//   rst          in   asynchronous reset, active low
//   mem_addr     in   byte address; word index is mem_addr[31:2]
//   mem_wdata    in   write data, captured with the write
//   mem_wstrobe  in   write request, held until mem_done
//   mem_rdata    out  read data, qualify with mem_done
//   mem_done     out  access complete
//   bus_err      out  completed access was misaligned or out of range
// -----------------------------------------------------------------------------
module bus_sram
    import bus_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_wstrobe,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        bus_err
);

    localparam int         INDEX_BITS = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD   = 4'(WAIT_STATES);

    bus_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic        err_q, err_d;
    logic        rzero_q, rzero_d;   // force mem_rdata to 0 (reset or bad read)
    logic [3:0]  cnt_q, cnt_d;

    logic        capture;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        addr_match;
    logic        req_err;

    assign addr_match = (mem_addr == addr_q);
    assign req_err    = addr_bad(mem_addr, INDEX_BITS);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        is_wr_d  = is_wr_q;
        err_d    = err_q;
        rzero_d  = rzero_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        mem_done = 1'b0;

        case (state_q)
            IDLE: capture = 1'b1;
            WAIT: begin
                if (!is_wr_q && !addr_match) begin
                    // Read target moved: start over on the new address.
                    capture = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ram_en = !err_q;
                    ram_we = is_wr_q;
                    if (is_wr_q) begin
                        state_d = WDONE;
                    end else begin
                        state_d = READY;
                        rzero_d = err_q;
                    end
                end
            end
            READY: begin
                // Combinational so done drops in the cycle the CPU moves on.
                mem_done = addr_match && !mem_wstrobe;
                capture  = mem_wstrobe || !addr_match;
            end
            WDONE: begin
                mem_done = mem_wstrobe;
                if (!mem_wstrobe) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            is_wr_d = mem_wstrobe;
            err_d   = req_err;
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
            rzero_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
            rzero_q <= rzero_d;
            cnt_q   <= cnt_d;
        end
    end

    sram_1p #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[ADDR_LSB +: INDEX_BITS]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // The array output register holds between reads, so mem_rdata keeps its
    // last value outside READY.
    assign mem_rdata = rzero_q ? '0 : ram_rdata;
    assign bus_err   = mem_done && err_q;

endmodule

// File: tb/tb_bus_sram.sv
// -----------------------------------------------------------------------------
// tb_bus_sram
// Directed bench for bus_sram. Stimulus tasks push the expected completion
// (cycle, error flag, read data) into a queue; a monitor pops one entry on
// every rising mem_done and compares.
// -----------------------------------------------------------------------------
module tb_bus_sram;

    localparam int          DEPTH = 256;
    localparam int          WS    = 2;
    localparam logic [31:0] OOR_ADDR = 32'(DEPTH * 4);

    typedef struct {
        int unsigned cyc;
        logic        is_wr;
        logic        err;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wstrobe;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        bus_err;

    int unsigned cyc;
    int          n_checks;
    int          n_fail;
    exp_t        exp_q[$];

    bus_sram #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrobe (mem_wstrobe),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Bounded wait for mem_done; returns at the negedge where it is seen.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_done === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    function automatic void expect_done(input string name, input logic is_wr,
                                        input logic err, input logic [31:0] data);
        exp_t e;
        // Inputs driven now are sampled at the next edge (cyc+1); done rises
        // WS+1 edges after that.
        e.cyc   = cyc + WS + 2;
        e.is_wr = is_wr;
        e.err   = err;
        e.data  = data;
        e.name  = name;
        exp_q.push_back(e);
    endfunction

    // All tasks start just after a rising edge and return just after one.
    task automatic bus_write(input string name, input logic [31:0] a,
                             input logic [31:0] d, input logic err);
        mem_addr    = a;
        mem_wdata   = d;
        mem_wstrobe = 1'b1;
        expect_done(name, 1'b1, err, 32'd0);
        wait_done(name);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({name, "_done_held"}, 32'(mem_done), 32'd1);
        end
        @(posedge clk); #2;
        mem_wstrobe = 1'b0;
        #1;
        check({name, "_done_drop"}, 32'(mem_done), 32'd0);
        @(posedge clk); #2;
    endtask

    task automatic bus_read(input string name, input logic [31:0] a,
                            input logic [31:0] d, input logic err);
        mem_addr    = a;
        mem_wstrobe = 1'b0;
        expect_done(name, 1'b0, err, d);
        wait_done(name);
        @(posedge clk); #2;
    endtask

    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_done === 1'b1 && prev_done !== 1'b1) begin
                check("response_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check({e.name, "_cycle"}, cyc, e.cyc);
                    check({e.name, "_err"}, 32'(bus_err), 32'(e.err));
                    if (!e.is_wr) check({e.name, "_rdata"}, mem_rdata, e.data);
                end
            end
            prev_done = mem_done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrobe = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset_done",  32'(mem_done), 32'd0);
        check("reset_err",   32'(bus_err),  32'd0);
        check("reset_rdata", mem_rdata,     32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Preload through the bus.
        bus_write("wr_w0",  32'h00, 32'h0BADF00D, 1'b0);
        bus_write("wr_w1",  32'h04, 32'h44444444, 1'b0);
        bus_write("wr_w2",  32'h08, 32'hC0FFEE08, 1'b0);
        bus_write("wr_w3",  32'h0C, 32'hDEADBEEF, 1'b0);
        bus_write("wr_w8",  32'h20, 32'h88888888, 1'b0);
        bus_write("wr_w16", 32'h40, 32'h12345678, 1'b0);

        bus_read("basic_read", 32'h0C, 32'hDEADBEEF, 1'b0);
        bus_read("readback",   32'h40, 32'h12345678, 1'b0);

        // Address moves after one cycle; only the second address completes.
        mem_addr = 32'h10;
        @(posedge clk); #2;
        bus_read("mid_wait_change", 32'h20, 32'h88888888, 1'b0);

        bus_read("misaligned_read", 32'h02, 32'h0, 1'b1);
        bus_write("oor_write", OOR_ADDR, 32'hFFFFFFFF, 1'b1);
        bus_read("word0_intact", 32'h00, 32'h0BADF00D, 1'b0);
        bus_write("misaligned_write", 32'h05, 32'hFFFFFFFF, 1'b1);
        bus_read("word1_intact", 32'h04, 32'h44444444, 1'b0);

        // Reset during the wait phase of a write.
        mem_addr    = 32'h08;
        mem_wdata   = 32'hAAAA5555;
        mem_wstrobe = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_mid_done",  32'(mem_done), 32'd0);
        check("rst_mid_err",   32'(bus_err),  32'd0);
        check("rst_mid_rdata", mem_rdata,     32'd0);
        @(posedge clk); #2;
        mem_wstrobe = 1'b0;
        rst         = 1'b1;
        bus_read("rst_write_dropped", 32'h08, 32'hC0FFEE08, 1'b0);

        // Repeated fetch of the same address completes without waiting.
        bus_read("fetch0", 32'h00, 32'h0BADF00D, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("refetch_done",  32'(mem_done), 32'd1);
            check("refetch_rdata", mem_rdata,     32'h0BADF00D);
            @(posedge clk); #2;
        end
        mem_addr = 32'h04;
        #1;
        check("done_drops_on_addr_change", 32'(mem_done), 32'd0);
        bus_read("fetch4", 32'h04, 32'h44444444, 1'b0);

        // A write invalidates READY data even at the same address.
        bus_write("overwrite_w1", 32'h04, 32'h55667788, 1'b0);
        bus_read("reread_w1", 32'h04, 32'h55667788, 1'b0);
        bus_read("oor_read", OOR_ADDR + 32'h4, 32'h0, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
